// File: rtl/hc4511.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | hc4511 : CD4511-style BCD-to-seven-segment decoder/latch with lamp test, |
// |          blanking and latch enable. Define HC4511_HEX_EN for hex glyphs. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hc4511 (
   input  logic       Clk,
   input  logic       Rst,
   input  logic [3:0] A,
   input  logic       LT_N,
   input  logic       BI_N,
   input  logic       LE,
   output logic [7:0] Seg
);

   logic [3:0] code_q;
   logic [3:0] w_code;
   logic [6:0] w_glyph;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         code_q <= 4'd0;
      end else if (!LE) begin
         code_q <= A;
      end
   end

   // Transparent while LE is low, so the scanner's digit shows without lag.
   assign w_code = LE ? code_q : A;

   always_comb begin
      w_glyph = 7'h00;
      case (w_code)
         4'd0:    w_glyph = 7'h3F;
         4'd1:    w_glyph = 7'h06;
         4'd2:    w_glyph = 7'h5B;
         4'd3:    w_glyph = 7'h4F;
         4'd4:    w_glyph = 7'h66;
         4'd5:    w_glyph = 7'h6D;
         4'd6:    w_glyph = 7'h7D;
         4'd7:    w_glyph = 7'h07;
         4'd8:    w_glyph = 7'h7F;
         4'd9:    w_glyph = 7'h6F;
`ifdef HC4511_HEX_EN
         4'd10:   w_glyph = 7'h77;
         4'd11:   w_glyph = 7'h7C;
         4'd12:   w_glyph = 7'h39;
         4'd13:   w_glyph = 7'h5E;
         4'd14:   w_glyph = 7'h79;
         4'd15:   w_glyph = 7'h71;
`else
         default: w_glyph = 7'h00;
`endif
      endcase
   end

   always_comb begin
      Seg = {1'b0, w_glyph};
      if (Rst) begin
         Seg = 8'h00;
      end else if (!LT_N) begin
         Seg = 8'hFF;
      end else if (!BI_N) begin
         Seg = 8'h00;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hc4511.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for hc4511: directed vector table plus latch, reset and scan sequences.
module tb_hc4511;

   logic       Clk;
   logic       Rst;
   logic [3:0] A;
   logic       LT_N;
   logic       BI_N;
   logic       LE;
   logic [7:0] Seg;

   int checks;
   int failures;

   typedef struct packed {
      logic [3:0] a;
      logic       lt_n;
      logic       bi_n;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [0:17];

   hc4511 dut (
      .Clk  (Clk),
      .Rst  (Rst),
      .A    (A),
      .LT_N (LT_N),
      .BI_N (BI_N),
      .LE   (LE),
      .Seg  (Seg)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [7:0] exp);
      checks++;
      if (Seg !== exp) begin
         failures++;
         $display("FAIL %s: Seg=%h expected %h", name, Seg, exp);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      vecs[0]  = '{4'd0,  1'b1, 1'b1, 8'h3F};
      vecs[1]  = '{4'd1,  1'b1, 1'b1, 8'h06};
      vecs[2]  = '{4'd2,  1'b1, 1'b1, 8'h5B};
      vecs[3]  = '{4'd3,  1'b1, 1'b1, 8'h4F};
      vecs[4]  = '{4'd4,  1'b1, 1'b1, 8'h66};
      vecs[5]  = '{4'd5,  1'b1, 1'b1, 8'h6D};
      vecs[6]  = '{4'd6,  1'b1, 1'b1, 8'h7D};
      vecs[7]  = '{4'd7,  1'b1, 1'b1, 8'h07};
      vecs[8]  = '{4'd8,  1'b1, 1'b1, 8'h7F};
      vecs[9]  = '{4'd9,  1'b1, 1'b1, 8'h6F};
`ifdef HC4511_HEX_EN
      vecs[10] = '{4'd10, 1'b1, 1'b1, 8'h77};
      vecs[11] = '{4'd11, 1'b1, 1'b1, 8'h7C};
      vecs[12] = '{4'd12, 1'b1, 1'b1, 8'h39};
      vecs[13] = '{4'd13, 1'b1, 1'b1, 8'h5E};
      vecs[14] = '{4'd14, 1'b1, 1'b1, 8'h79};
      vecs[15] = '{4'd15, 1'b1, 1'b1, 8'h71};
`else
      vecs[10] = '{4'd10, 1'b1, 1'b1, 8'h00};
      vecs[11] = '{4'd11, 1'b1, 1'b1, 8'h00};
      vecs[12] = '{4'd12, 1'b1, 1'b1, 8'h00};
      vecs[13] = '{4'd13, 1'b1, 1'b1, 8'h00};
      vecs[14] = '{4'd14, 1'b1, 1'b1, 8'h00};
      vecs[15] = '{4'd15, 1'b1, 1'b1, 8'h00};
`endif
      vecs[16] = '{4'd12, 1'b0, 1'b0, 8'hFF};
      vecs[17] = '{4'd8,  1'b1, 1'b0, 8'h00};

      // Reset state: blank even with lamp test asserted.
      Rst = 1'b1; A = 4'd8; LT_N = 1'b1; BI_N = 1'b1; LE = 1'b0;
      #2;
      chk("reset_blank", 8'h00);
      LT_N = 1'b0;
      #1;
      chk("reset_over_lt", 8'h00);
      LT_N = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;

      // Table sweep, transparent mode.
      for (int i = 0; i < 18; i++) begin
         @(negedge Clk);
         A    = vecs[i].a;
         LT_N = vecs[i].lt_n;
         BI_N = vecs[i].bi_n;
         LE   = 1'b0;
         #1;
         chk($sformatf("vec%0d_a%0d", i, vecs[i].a), vecs[i].exp);
      end

      // Latch hold: capture 5, then A changes to 2 while held.
      @(negedge Clk);
      LT_N = 1'b1; BI_N = 1'b1; LE = 1'b0; A = 4'd5;
      @(posedge Clk);
      #1;
      LE = 1'b1; A = 4'd2;
      #1;
      chk("latch_hold_now", 8'h6D);
      for (int i = 0; i < 3; i++) begin
         @(posedge Clk);
         #1;
         chk($sformatf("latch_hold_clk%0d", i), 8'h6D);
      end
      LE = 1'b0;
      #1;
      chk("latch_release", 8'h5B);

      // LT_N/BI_N across edges must not disturb the stored code.
      @(negedge Clk);
      A = 4'd4;
      @(posedge Clk);
      #1;
      LE = 1'b1; A = 4'd9; LT_N = 1'b0;
      #1;
      chk("lt_while_held", 8'hFF);
      @(posedge Clk);
      #1;
      LT_N = 1'b1; BI_N = 1'b0;
      @(posedge Clk);
      #1;
      BI_N = 1'b1;
      #1;
      chk("held_after_lt_bi", 8'h66);

      // Asynchronous reset between edges while holding 7.
      @(negedge Clk);
      LE = 1'b0; A = 4'd7;
      @(posedge Clk);
      #1;
      LE = 1'b1; A = 4'd1;
      #1;
      chk("hold7", 8'h07);
      #1;
      Rst = 1'b1;
      #1;
      chk("rst_pulse", 8'h00);
      Rst = 1'b0;
      #1;
      chk("after_rst_held", 8'h3F);
      @(posedge Clk);
      #1;
      chk("after_rst_clk", 8'h3F);

      // Scanner usage: new digit each clock, no lag.
      LE = 1'b0;
      A  = 4'd6;
      #1;
      chk("scan0", 8'h7D);
      @(posedge Clk); #1; A = 4'd0; #1; chk("scan1", 8'h3F);
      @(posedge Clk); #1; A = 4'd5; #1; chk("scan2", 8'h6D);
      @(posedge Clk); #1; A = 4'd5; #1; chk("scan3", 8'h6D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
